// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the eight M-extension ops
//   muldiv_state_e : controller states
//   is_div         : op belongs to the divide/remainder half
//   rs1_signed / rs2_signed : operand signedness per op
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : 2*XLEN accumulator; multiply {hi, multiplier}, divide {remainder, quotient/dividend}
//   opnd_i   : multiplicand (multiply) or divisor (divide)
//   acc_o    : accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        // Multiply: conditionally add multiplicand into the high half, then shift right.
        add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: remainder shifted left with the next dividend bit pulled in.
        shifted = acc_i[2*XLEN-1:XLEN-1];
        ge      = shifted >= {1'b0, opnd_i};
        // The true difference is below the divisor, so the low XLEN bits are exact.
        diff    = shifted[XLEN-1:0] - opnd_i;
        if (is_div_i) begin
            acc_o = {(ge ? diff : shifted[XLEN-1:0]), acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : abort in-flight op / discard held result
//   in_valid, in_ready  : op handshake (op = funct3, rs1, rs2)
//   out_valid, out_ready: result handshake; result held while out_valid && !out_ready
//
//   state | meaning
//   IDLE  | waiting for an op, in_ready=1
//   CALC  | one iteration per cycle, counter 0..XLEN
//   DONE  | result valid, waiting for out_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int               CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_op_e        op_in;
    logic              sa, sb, accept, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res, quo, rem;
    logic [2*XLEN-1:0] step_acc, prod_fix;

    assign op_in = muldiv_op_e'(op);
    assign sa    = rs1_signed(op_in) & rs1[XLEN-1];
    assign sb    = rs2_signed(op_in) & rs2[XLEN-1];
    assign mag_a = sa ? -rs1 : rs1;
    assign mag_b = sb ? -rs2 : rs2;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    // Divide-by-zero and signed overflow finish without iterating.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (is_div(op_in)) begin
            if (rs2 == '0) begin
                special     = 1'b1;
                special_res = op_in[1] ? rs1 : '1;
            end else if (!op_in[0] && (rs1 == MIN_INT) && (rs2 == '1)) begin
                special     = 1'b1;
                special_res = op_in[1] ? '0 : MIN_INT;
            end
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div(op_q)),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    // Sign fix applied to the final iteration's output as it is registered.
    always_comb begin
        prod_fix = neg_q ? -step_acc : step_acc;
        quo      = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem      = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo;
            default:                      final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d   = op_in;
                        // Remainder follows the dividend; everything else follows sA^sB.
                        neg_d  = (op_in[2] && op_in[1]) ? sa : (sa ^ sb);
                        cnt_d  = '0;
                        opnd_d = is_div(op_in) ? mag_b : mag_a;
                        acc_d  = {{XLEN{1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
                        if (special) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LAST) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule
